// File: rtl/ads_bus_pkg.sv
// Shared types and constants for the ads serial bus slave endpoint.
// ADS_SLAVE_WR_ACK_EN adds the write-acknowledge states to the FSM encoding.
package ads_bus_pkg;

   localparam int   LOCAL_ADDR_W = 12;
   localparam int   DATA_W       = 8;
   localparam logic START_BIT    = 1'b1;
   localparam logic ACK_OK       = 1'b1;
   localparam logic ACK_NACK     = 1'b0;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } frame_mode_e;

   typedef enum logic [3:0] {
      IDLE,
      MODE,
      ADDR,
      WDATA,
      COMMIT,
      MEMRD,
      RSP_START,
      RSP_DATA
`ifdef ADS_SLAVE_WR_ACK_EN
      ,
      ACK_START,
      ACK_STAT
`endif
   } slave_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ads_slave_mem.sv
// Single-port synchronous byte RAM with write enable and registered read.
// Contents are intentionally not reset.
module ads_slave_mem #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/ads_slave_port.sv
// Serial bus slave endpoint: parses request frames on rx, accesses local memory,
// returns read data on tx. ADS_SLAVE_WR_ACK_EN enables write acknowledge frames.
module ads_slave_port #(
   parameter int ADDR_W = ads_bus_pkg::LOCAL_ADDR_W,
   parameter int DATA_W = ads_bus_pkg::DATA_W
) (
   input  logic clk,
   input  logic rstn,
   input  logic rx,
   output logic tx,
   input  logic busy,
   output logic active
);

   import ads_bus_pkg::*;

   localparam int CNT_W = $clog2(max_int(ADDR_W, DATA_W));

   slave_state_e      state, next_state;
   frame_mode_e       mode;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata, rdata, rsp_sh;
   logic              we, re, addr_last, data_last, counting;
`ifdef ADS_SLAVE_WR_ACK_EN
   logic              ack_st;
`endif

   assign addr_last = (cnt == CNT_W'(ADDR_W - 1));
   assign data_last = (cnt == CNT_W'(DATA_W - 1));
   assign counting  = (state == ADDR) || (state == WDATA) || (state == RSP_DATA);
   assign active    = (state != IDLE);

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      tx         = 1'b0;
      we         = 1'b0;
      re         = 1'b0;
      unique case (state)
         IDLE:      if (rx == START_BIT) next_state = MODE;
         MODE:      next_state = ADDR;
         ADDR:
            if (addr_last) begin
               if (mode == WRITE) next_state = WDATA;
               else if (busy)     next_state = IDLE;
               else               next_state = MEMRD;
            end
         WDATA:
            if (data_last) begin
`ifdef ADS_SLAVE_WR_ACK_EN
               next_state = busy ? ACK_START : COMMIT;
`else
               next_state = busy ? IDLE : COMMIT;
`endif
            end
         COMMIT: begin
            we = 1'b1;
`ifdef ADS_SLAVE_WR_ACK_EN
            next_state = ACK_START;
`else
            next_state = IDLE;
`endif
         end
         MEMRD: begin
            re         = 1'b1;
            next_state = RSP_START;
         end
         RSP_START: begin
            tx         = START_BIT;
            next_state = RSP_DATA;
         end
         RSP_DATA: begin
            tx = rsp_sh[0];
            if (data_last) next_state = IDLE;
         end
`ifdef ADS_SLAVE_WR_ACK_EN
         ACK_START: begin
            tx         = START_BIT;
            next_state = ACK_STAT;
         end
         ACK_STAT: begin
            tx         = ack_st;
            next_state = IDLE;
         end
`endif
         default:   next_state = IDLE;
      endcase
   end

   // Bit counter restarts at 0 on every field boundary.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         cnt    <= '0;
         mode   <= READ;
         addr   <= '0;
         wdata  <= '0;
         rsp_sh <= '0;
      end else begin
         cnt <= (counting && next_state == state) ? cnt + 1'b1 : '0;
         if (state == MODE)      mode   <= frame_mode_e'(rx);
         if (state == ADDR)      addr   <= {rx, addr[ADDR_W-1:1]};
         if (state == WDATA)     wdata  <= {rx, wdata[DATA_W-1:1]};
         if (state == RSP_START) rsp_sh <= rdata;
         if (state == RSP_DATA)  rsp_sh <= rsp_sh >> 1;
      end
   end

`ifdef ADS_SLAVE_WR_ACK_EN
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn)                          ack_st <= ACK_NACK;
      else if (state == WDATA && data_last) ack_st <= busy ? ACK_NACK : ACK_OK;
   end
`endif

   ads_slave_mem #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .re    (re),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata)
   );

endmodule

// File: doc/ads_slave_port.md
# ads_slave_port

Serial bus slave endpoint with local byte-wide memory, sitting directly downstream of `address_decoder` on one `sN_rx`/`sN_tx` pair. It consumes the routed request frame (the decoder has already stripped the 2-bit slave select from the 14-bit bus address), performs a write or read on a 2^ADDR_W x 8 synchronous memory, and drives the response frame back toward the decoder. A `busy` input lets the system force request drops, which exercises the decoder's no-response path.

## Interface
- ADDR_W, 12, local address width; memory depth is 2^ADDR_W bytes.
- DATA_W, 8, data word width; bits per data field.
- clk  input  1  sole clock; all logic on rising edge.
- rstn  input  1  reset; asynchronous, active-high (1 = in reset).
- rx  input  1  request line from `address_decoder`; idles 0.
- tx  output  1  response line to `address_decoder`; idles 0.
- busy  input  1  1 = drop the current request; sampled once per frame.
- active  output  1  1 whenever the FSM is not in IDLE.

## Operation
- Request frame on rx, one bit per clk: start bit (1), mode bit (1 = write, 0 = read), ADDR_W address bits LSB first, then DATA_W data bits LSB first for writes only.
- FSM states: IDLE, MODE, ADDR, WDATA, COMMIT, MEMRD, RSP_START, RSP_DATA, plus ACK_START and ACK_STAT when ADS_SLAVE_WR_ACK_EN is defined.
- IDLE -> MODE when rx=1. MODE latches the mode bit. ADDR shifts in address bits using a bit counter sized $clog2(max(ADDR_W,DATA_W)); the counter wraps to 0 on each field change.
- After the last address bit, a read goes to MEMRD and a write goes to WDATA. After the last data bit, WDATA goes to COMMIT.
- busy is sampled on the cycle the final request bit is captured: the last address bit for reads, the last data bit for writes.
  - busy=1 on a read: return to IDLE, no response.
  - busy=1 on a write: no memory write. Without the ACK macro, return to IDLE. With the macro, send a NACK.
- COMMIT writes mem[addr] = data, then returns to IDLE (or goes to ACK_START with the macro).
- MEMRD asserts the read enable. Data is registered the next cycle. RSP_START drives tx=1, then RSP_DATA drives DATA_W bits LSB first, then IDLE.
- rx is ignored outside IDLE (half-duplex). A 1 on rx while a response is in progress is not a start bit.
- Reset mid-frame or mid-response: FSM returns to IDLE, tx=0, active=0 immediately (asynchronous). Memory contents are not reset and are undefined after power-up.

## Timing
- Reset values: tx=0, active=0, FSM=IDLE, counters 0.
- Taking the request start bit on rx at cycle 0: mode at cycle 1, address bits at cycles 2..ADDR_W+1 (2..13 at the default).
- Read: MEMRD at cycle 14, tx start bit at cycle 15, data bits at 16..23, tx=0 and IDLE at cycle 24. The earliest next start bit accepted is cycle 24.
- Write: data bits at cycles 14..21, COMMIT (memory written) at cycle 22, IDLE at cycle 23.
- Back-to-back writes: a new start bit is accepted at cycle 23.
- A read of an address written by the immediately preceding frame returns the new data; COMMIT precedes MEMRD by at least 2 cycles.
- active is 1 from cycle 1 through the last response bit.

## Configuration
- ADS_SLAVE_WR_ACK_EN defined:
  - every completed write frame is acknowledged: ACK_START drives tx=1 one cycle after COMMIT (cycle 23), then ACK_STAT drives the status bit (cycle 24), then IDLE at cycle 25;
  - status 1 = written, 0 = dropped by busy;
  - a busy-dropped write skips COMMIT; ACK_START is at cycle 22 and status 0 at cycle 23.
- ADS_SLAVE_WR_ACK_EN undefined: writes are silent; the ACK states and logic are absent.
- Reads behave the same either way.

## Structure
- Shared package `ads_bus_pkg`: `frame_mode_e` (READ=0, WRITE=1), the FSM state enum, START_BIT=1'b1, LOCAL_ADDR_W=12, DATA_W=8, ACK_OK=1'b1 and ACK_NACK=1'b0.
- One sub-module: `ads_slave_mem`, a 2^ADDR_W x DATA_W single-port synchronous RAM with write enable and registered read.

## Test plan
- Write 0xA5 to address 0x123 with busy=0, then read 0x123 -> tx shows 1 at cycle 15, then bits of 0xA5 LSB first (1,0,1,0,0,1,0,1); tx=0 at cycle 24.
- Read address 0x7FF with busy=1 at cycle 13 -> tx stays 0 for the whole frame; active=0 at cycle 14; a read frame starting at cycle 14 is served normally.
- Write 0x3C to 0x010 with busy=1 at cycle 21, then read 0x010 -> the read returns the prior value, not 0x3C. With ADS_SLAVE_WR_ACK_EN, the write shows tx=1 at cycle 22 and 0 at cycle 23.
- ADS_SLAVE_WR_ACK_EN, write 0xFF to 0xFFF -> tx=1 at cycles 23 and 24; immediately followed by a read of 0xFFF, which returns 0xFF.
- rx pulsed 1 during RSP_DATA of a read -> response is unaffected and no second frame starts.
- Assert rstn at cycle 18 of a read -> tx=0 and active=0 in the same cycle; after release, a new write frame completes correctly.
